// File: rtl/burst_main_memory_pkg.sv
// main_mem_pkg: shared FSM state type, sizing limits and constant helpers
// for burst_main_memory and its burst address generator.
package main_mem_pkg;

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_BURST} state_t;

    localparam int MAX_BURST_LEN = 16;
    localparam int MAX_RD_LAT    = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Beat counter must hold 0..MAX_BURST_LEN; wait counter 0..MAX_RD_LAT-2.
    localparam int CNT_W = clog2(MAX_BURST_LEN) + 1;
    localparam int LAT_W = clog2(MAX_RD_LAT);

endpackage

// File: rtl/burst_main_memory_addr_gen.sv
// burst_addr_gen: wrapped beat address and beat-counter step for a burst.
//   base_i    in  latched start word address of the burst
//   cnt_i     in  current beat index
//   inc_i     in  advance to the next beat
//   addr_o    out word address of beat cnt_i, wrapped inside the aligned line
//   cnt_nxt_o out beat index after this cycle
//   last_o    out cnt_i is the final beat of the line
module burst_addr_gen
    import main_mem_pkg::*;
#(
    parameter int AWIDTH    = 9,
    parameter int BURST_LEN = 4
)(
    input  logic [AWIDTH-1:0] base_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              inc_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic [CNT_W-1:0]  cnt_nxt_o,
    output logic              last_o
);

    // Line bits come from the base; only the offset bits wrap, so a burst
    // never leaves its line (including the top line of memory).
    localparam logic [AWIDTH-1:0] MASK = AWIDTH'(BURST_LEN - 1);

    assign addr_o    = (base_i & ~MASK) | ((base_i + AWIDTH'(cnt_i)) & MASK);
    assign last_o    = cnt_i == CNT_W'(BURST_LEN - 1);
    assign cnt_nxt_o = cnt_i + CNT_W'(inc_i);

endmodule

// File: rtl/burst_main_memory.sv
// burst_main_memory: single-port synchronous RAM with wrapped line bursts.
module burst_main_memory
    import main_mem_pkg::*;
#(
    parameter int AWIDTH    = 9,
    parameter int DWIDTH    = 8,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 1
`ifdef BURST_MAIN_MEMORY_INIT_EN
    ,
    parameter string INIT_FILE = "memory.txt"
`endif
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              data_in_valid,
    output logic              ready_mem,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              data_last
);

    if (!is_pow2(BURST_LEN) || BURST_LEN > MAX_BURST_LEN) begin : g_bad_burst
        $error("BURST_LEN must be a power of two in 1..%0d", MAX_BURST_LEN);
    end
    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("RD_LAT must be in 1..%0d", MAX_RD_LAT);
    end

    localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [AWIDTH-1:0] beat_addr, waddr;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              beat_last, inc, we;

    assign inc = (state_q == WR && data_in_valid) || state_q == RD_BURST;

    burst_addr_gen #(.AWIDTH(AWIDTH), .BURST_LEN(BURST_LEN)) u_addr_gen (
        .base_i    (base_q),
        .cnt_i     (cnt_q),
        .inc_i     (inc),
        .addr_o    (beat_addr),
        .cnt_nxt_o (cnt_nxt),
        .last_o    (beat_last)
    );

    assign ready_mem  = state_q == IDLE && !valid_q;
    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign data_last  = last_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        we      = 1'b0;
        waddr   = beat_addr;
        case (state_q)
            IDLE: begin
                if (ready_mem && wr_mem) begin
                    we      = 1'b1;
                    waddr   = addr_mem;
                    base_d  = addr_mem;
                    cnt_d   = CNT_W'(1);
                    state_d = (BURST_LEN == 1) ? IDLE : WR;
                end else if (ready_mem && rd_mem) begin
                    base_d  = addr_mem;
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = (RD_LAT > 1) ? RD_WAIT : RD_BURST;
                end
            end
            WR: begin
                we    = data_in_valid;
                cnt_d = cnt_nxt;
                if (data_in_valid && beat_last) state_d = IDLE;
            end
            RD_WAIT: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == WAIT_LAST) state_d = RD_BURST;
            end
            RD_BURST: begin
                dout_d  = mem_q[beat_addr];
                valid_d = 1'b1;
                last_d  = beat_last;
                cnt_d   = cnt_nxt;
                if (beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && we) mem_q[waddr] <= data_in;
    end

endmodule

// File: tb/tb_burst_main_memory.sv
// tb_burst_main_memory: directed checks of burst_main_memory with RD_LAT=1 (unit 0) and RD_LAT=3 (unit 1).
module tb_burst_main_memory;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rd_mem[2], wr_mem[2], data_in_valid[2];
    logic       ready_mem[2], data_valid[2], data_last[2];
    logic [8:0] addr_mem[2];
    logic [7:0] data_in[2], data_out[2];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] beats[4];
    logic [3:0] lasts;
    int         n_beats, lat_seen;

    always #5 clk = ~clk;

    burst_main_memory #(.AWIDTH(9), .DWIDTH(8), .BURST_LEN(4), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .rd_mem(rd_mem[0]), .wr_mem(wr_mem[0]),
        .addr_mem(addr_mem[0]), .data_in(data_in[0]), .data_in_valid(data_in_valid[0]),
        .ready_mem(ready_mem[0]), .data_out(data_out[0]), .data_valid(data_valid[0]),
        .data_last(data_last[0])
    );

    burst_main_memory #(.AWIDTH(9), .DWIDTH(8), .BURST_LEN(4), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .rd_mem(rd_mem[1]), .wr_mem(wr_mem[1]),
        .addr_mem(addr_mem[1]), .data_in(data_in[1]), .data_in_valid(data_in_valid[1]),
        .ready_mem(ready_mem[1]), .data_out(data_out[1]), .data_valid(data_valid[1]),
        .data_last(data_last[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input int u, input logic [8:0] a, input logic [31:0] d, input int gap);
        wr_mem[u] = 1'b1;
        addr_mem[u] = a;
        data_in[u] = d[31:24];
        tick;
        wr_mem[u] = 1'b0;
        for (int k = 1; k < 4; k++) begin
            repeat (gap) tick;
            data_in[u] = d[31-8*k -: 8];
            data_in_valid[u] = 1'b1;
            tick;
            data_in_valid[u] = 1'b0;
        end
    endtask

    task automatic rd_capture(input int u, input logic [8:0] a);
        for (int k = 0; k < 4; k++) beats[k] = 8'hxx;
        lasts = 4'b0;
        n_beats = 0;
        lat_seen = 0;
        rd_mem[u] = 1'b1;
        addr_mem[u] = a;
        tick;
        rd_mem[u] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (data_valid[u] === 1'b1) begin
                if (n_beats == 0) lat_seen = c;
                if (n_beats < 4) begin
                    beats[n_beats] = data_out[u];
                    lasts[3-n_beats] = data_last[u];
                end
                n_beats++;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick;
        for (int u = 0; u < 2; u++) begin
            checks++; if (ready_mem[u] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", u, ready_mem[u]); end
            checks++; if (data_valid[u] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", u, data_valid[u]); end
            checks++; if (data_last[u] !== 1'b0) begin errors++; $display("FAIL reset_last[%0d]: got %b want 0", u, data_last[u]); end
            checks++; if (data_out[u] !== 8'h00) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 00", u, data_out[u]); end
        end
        reset_n = 1'b1;
        tick;
        checks++; if (ready_mem[0] !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", ready_mem[0]); end
    endtask

    task automatic test_aligned;
        logic [7:0] e[4];
        e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        wr_burst(0, 9'h010, 32'hA0A1A2A3, 0);
        checks++; if (ready_mem[0] !== 1'b1) begin errors++; $display("FAIL aligned_wr_ready: got %b want 1", ready_mem[0]); end
        rd_capture(0, 9'h010);
        checks++; if (lat_seen != 1) begin errors++; $display("FAIL aligned_latency: got %0d want 1", lat_seen); end
        checks++; if (n_beats != 4) begin errors++; $display("FAIL aligned_nbeats: got %0d want 4", n_beats); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (beats[k] !== e[k]) begin errors++; $display("FAIL aligned_beat%0d: got %h want %h", k, beats[k], e[k]); end
        end
        checks++; if (lasts !== 4'b0001) begin errors++; $display("FAIL aligned_last: got %b want 0001", lasts); end
        checks++; if (data_out[0] !== 8'hA3) begin errors++; $display("FAIL aligned_dout_hold: got %h want a3", data_out[0]); end
        checks++; if (data_valid[0] !== 1'b0 || ready_mem[0] !== 1'b1) begin errors++; $display("FAIL aligned_idle: valid %b ready %b want 0 1", data_valid[0], ready_mem[0]); end
    endtask

    task automatic test_wrap;
        logic [7:0] e[4];
        wr_burst(0, 9'h014, 32'hB0B1B2B3, 0);
        rd_capture(0, 9'h012);
        e = '{8'hA2, 8'hA3, 8'hA0, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            checks++; if (beats[k] !== e[k]) begin errors++; $display("FAIL wrap_rd_beat%0d: got %h want %h", k, beats[k], e[k]); end
        end
        checks++; if (lasts !== 4'b0001 || n_beats != 4) begin errors++; $display("FAIL wrap_rd_last: got %b/%0d want 0001/4", lasts, n_beats); end
        rd_capture(0, 9'h014);
        checks++; if (beats[0] !== 8'hB0) begin errors++; $display("FAIL wrap_next_line: got %h want b0", beats[0]); end
        wr_burst(0, 9'h016, 32'hC0C1C2C3, 0);
        rd_capture(0, 9'h014);
        e = '{8'hC2, 8'hC3, 8'hC0, 8'hC1};
        for (int k = 0; k < 4; k++) begin
            checks++; if (beats[k] !== e[k]) begin errors++; $display("FAIL wrap_wr_beat%0d: got %h want %h", k, beats[k], e[k]); end
        end
    endtask

    task automatic test_write_stall;
        logic [7:0] e[4];
        e = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        wr_mem[0] = 1'b1;
        addr_mem[0] = 9'h020;
        data_in[0] = e[0];
        tick;
        wr_mem[0] = 1'b0;
        for (int k = 1; k < 4; k++) begin
            repeat (2) begin
                data_in[0] = 8'hEE;
                tick;
                checks++; if (ready_mem[0] !== 1'b0) begin errors++; $display("FAIL stall_gap_ready beat%0d: got %b want 0", k, ready_mem[0]); end
            end
            data_in[0] = e[k];
            data_in_valid[0] = 1'b1;
            tick;
            data_in_valid[0] = 1'b0;
            checks++; if (ready_mem[0] !== (k == 3)) begin errors++; $display("FAIL stall_beat_ready beat%0d: got %b want %b", k, ready_mem[0], k == 3); end
        end
        data_in[0] = 8'hEE;
        data_in_valid[0] = 1'b1;
        tick;
        data_in_valid[0] = 1'b0;
        checks++; if (ready_mem[0] !== 1'b1) begin errors++; $display("FAIL stall_idle_valid_ready: got %b want 1", ready_mem[0]); end
        rd_capture(0, 9'h020);
        for (int k = 0; k < 4; k++) begin
            checks++; if (beats[k] !== e[k]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", k, beats[k], e[k]); end
        end
    endtask

    task automatic test_collision;
        logic [7:0] e[4];
        logic       any_valid;
        e = '{8'hE2, 8'hE3, 8'hE0, 8'hE1};
        any_valid = 1'b0;
        wr_mem[1] = 1'b1;
        rd_mem[1] = 1'b1;
        addr_mem[1] = 9'h1FC;
        data_in[1] = 8'hE0;
        tick;
        wr_mem[1] = 1'b0;
        rd_mem[1] = 1'b0;
        any_valid |= data_valid[1];
        checks++; if (ready_mem[1] !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b want 0", ready_mem[1]); end
        for (int k = 1; k < 4; k++) begin
            data_in[1] = 8'hE0 + 8'(k);
            data_in_valid[1] = 1'b1;
            tick;
            any_valid |= data_valid[1];
        end
        data_in_valid[1] = 1'b0;
        checks++; if (ready_mem[1] !== 1'b1) begin errors++; $display("FAIL coll_wr_done: got %b want 1", ready_mem[1]); end
        repeat (6) begin
            tick;
            any_valid |= data_valid[1];
        end
        checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL coll_read_dropped: data_valid seen %b want 0", any_valid); end
        rd_capture(1, 9'h1FE);
        checks++; if (lat_seen != 3) begin errors++; $display("FAIL lat3_latency: got %0d want 3", lat_seen); end
        checks++; if (n_beats != 4 || lasts !== 4'b0001) begin errors++; $display("FAIL lat3_beats: got %0d/%b want 4/0001", n_beats, lasts); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (beats[k] !== e[k]) begin errors++; $display("FAIL lat3_beat%0d: got %h want %h", k, beats[k], e[k]); end
        end
    endtask

    task automatic test_back_to_back;
        logic found;
        found = 1'b0;
        rd_mem[0] = 1'b1;
        addr_mem[0] = 9'h010;
        tick;
        rd_mem[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (data_valid[0] === 1'b1 && data_last[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL b2b_last_seen: got %b want 1", found); end
        checks++; if (ready_mem[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_on_last: got %b want 0", ready_mem[0]); end
        tick;
        checks++; if (ready_mem[0] !== 1'b1 || data_valid[0] !== 1'b0 || data_last[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_after_last: ready %b valid %b last %b want 1 0 0", ready_mem[0], data_valid[0], data_last[0]);
        end
        rd_mem[0] = 1'b1;
        addr_mem[0] = 9'h020;
        tick;
        rd_mem[0] = 1'b0;
        checks++; if (ready_mem[0] !== 1'b0) begin errors++; $display("FAIL b2b_accept: ready got %b want 0", ready_mem[0]); end
        tick;
        checks++; if (data_valid[0] !== 1'b1 || data_out[0] !== 8'hD0) begin errors++; $display("FAIL b2b_first_beat: valid %b data %h want 1 d0", data_valid[0], data_out[0]); end
        repeat (6) tick;
    endtask

    task automatic test_reset_mid;
        logic any_valid;
        any_valid = 1'b0;
        rd_mem[0] = 1'b1;
        addr_mem[0] = 9'h010;
        tick;
        rd_mem[0] = 1'b0;
        tick;
        checks++; if (data_valid[0] !== 1'b1 || data_out[0] !== 8'hA0) begin errors++; $display("FAIL mid_beat0: valid %b data %h want 1 a0", data_valid[0], data_out[0]); end
        reset_n = 1'b0;
        tick;
        checks++; if (ready_mem[0] !== 1'b1 || data_valid[0] !== 1'b0 || data_out[0] !== 8'h00 || data_last[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset: ready %b valid %b data %h last %b want 1 0 00 0", ready_mem[0], data_valid[0], data_out[0], data_last[0]);
        end
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (6) begin
            tick;
            any_valid |= data_valid[0];
        end
        checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL mid_no_more_beats: valid seen %b want 0", any_valid); end
        rd_capture(0, 9'h010);
        checks++; if (beats[0] !== 8'hA0 || beats[3] !== 8'hA3) begin errors++; $display("FAIL mid_ram_kept: got %h..%h want a0..a3", beats[0], beats[3]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rd_mem[u] = 1'b0;
            wr_mem[u] = 1'b0;
            data_in_valid[u] = 1'b0;
            addr_mem[u] = '0;
            data_in[u] = '0;
        end
        test_reset;
        test_aligned;
        test_wrap;
        test_write_stall;
        test_collision;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
